// File: rtl/mod_mul_pkg.sv
// rtl/mod_mul_pkg.sv - shared widths and latency for the 64x64 integer multiplier (INT_MUL_IN_REG_EN adds an input stage)
package mod_mul_pkg;

  localparam int Q_LEN      = 64;
  localparam int LIMB_W     = 16;
  localparam int NUM_LIMBS  = Q_LEN / LIMB_W;
  localparam int C_LEN      = 2 * Q_LEN;

  // partial product, aligned row sum, and pair sum widths
  localparam int PP_W       = 2 * LIMB_W;
  localparam int ROW_W      = Q_LEN + LIMB_W;
  localparam int PAIR_W     = ROW_W + LIMB_W + 1;

  // S1..S4 arithmetic stages; the optional input stage sits in front of them
  localparam int MUL_STAGES = 4;

`ifdef INT_MUL_IN_REG_EN
  localparam int INT_MUL_LAT = MUL_STAGES + 1;
`else
  localparam int INT_MUL_LAT = MUL_STAGES;
`endif

endpackage

// File: rtl/int_mul_pipe_if.sv
// rtl/int_mul_pipe_if.sv - operand/product bundle between the producer, the multiplier and the reduction stage
interface int_mul_pipe_if;
  import mod_mul_pkg::*;

  logic               in_valid;
  logic [Q_LEN-1:0]   a;
  logic [Q_LEN-1:0]   b;
  logic [Q_LEN-1:0]   q_in;
  logic               out_valid;
  logic [C_LEN-1:0]   C;
  logic [Q_LEN-1:0]   q_out;

  // producer side: drives operands, observes the product
  modport master (
    output in_valid, a, b, q_in,
    input  out_valid, C, q_out
  );

  // multiplier side
  modport slave (
    input  in_valid, a, b, q_in,
    output out_valid, C, q_out
  );

endinterface

// File: rtl/int_mul_pipe_row.sv
// rtl/int_mul_pipe_row.sv - one row of the limb multiplier: a * b_limb over two registered stages
module mul_limb_row
  import mod_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [Q_LEN-1:0]  a,
  input  logic [LIMB_W-1:0] b_limb,
  output logic [ROW_W-1:0]  row
);

  logic [PP_W-1:0]  pp_d [NUM_LIMBS];
  logic [PP_W-1:0]  pp_q [NUM_LIMBS];
  logic [ROW_W-1:0] row_d;
  logic [ROW_W-1:0] row_q;

  // S1: one limb x limb partial product per limb of a
  always_comb begin
    for (int i = 0; i < NUM_LIMBS; i++) begin
      pp_d[i] = PP_W'(a[i*LIMB_W +: LIMB_W]) * PP_W'(b_limb);
    end
  end

  // S2: shift each partial product to its limb position and sum
  always_comb begin
    logic [ROW_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_LIMBS; i++) begin
      acc = acc + (ROW_W'(pp_q[i]) << (i * LIMB_W));
    end
    row_d = acc;
  end

  // S1/S2 registers, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LIMBS; i++) begin
        pp_q[i] <= '0;
      end
      row_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LIMBS; i++) begin
        pp_q[i] <= pp_d[i];
      end
      row_q <= row_d;
    end
  end

  assign row = row_q;

endmodule

// File: rtl/int_mul_pipe.sv
// rtl/int_mul_pipe.sv - pipelined 64x64->128 unsigned multiplier with modulus side channel (INT_MUL_IN_REG_EN adds S0)
module int_mul_pipe
  import mod_mul_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  int_mul_pipe_if.slave bus
);

  logic               mul_valid;
  logic [Q_LEN-1:0]   mul_a;
  logic [Q_LEN-1:0]   mul_b;
  logic [Q_LEN-1:0]   mul_q;

`ifdef INT_MUL_IN_REG_EN
  logic               in_valid_d, in_valid_q;
  logic [Q_LEN-1:0]   in_a_d, in_a_q;
  logic [Q_LEN-1:0]   in_b_d, in_b_q;
  logic [Q_LEN-1:0]   in_q_d, in_q_q;

  // S0: capture the raw ports before the multiplier array
  always_comb begin
    in_valid_d = bus.in_valid;
    in_a_d     = bus.a;
    in_b_d     = bus.b;
    in_q_d     = bus.q_in;
  end

  // S0 registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_q <= 1'b0;
      in_a_q     <= '0;
      in_b_q     <= '0;
      in_q_q     <= '0;
    end else begin
      in_valid_q <= in_valid_d;
      in_a_q     <= in_a_d;
      in_b_q     <= in_b_d;
      in_q_q     <= in_q_d;
    end
  end

  assign mul_valid = in_valid_q;
  assign mul_a     = in_a_q;
  assign mul_b     = in_b_q;
  assign mul_q     = in_q_q;
`else
  assign mul_valid = bus.in_valid;
  assign mul_a     = bus.a;
  assign mul_b     = bus.b;
  assign mul_q     = bus.q_in;
`endif

  // S1+S2: one row per limb of b
  logic [ROW_W-1:0] r [NUM_LIMBS];

  for (genvar j = 0; j < NUM_LIMBS; j++) begin : g_row
    mul_limb_row u_row (
      .clk    (clk),
      .rst    (rst),
      .a      (mul_a),
      .b_limb (mul_b[j*LIMB_W +: LIMB_W]),
      .row    (r[j])
    );
  end

  logic [PAIR_W-1:0] s0_d, s0_q;
  logic [PAIR_W-1:0] s1_d, s1_q;
  logic [C_LEN-1:0]  c_d, c_q;

  // S3: combine adjacent rows into two pair sums
  always_comb begin
    s0_d = PAIR_W'(r[0]) + (PAIR_W'(r[1]) << LIMB_W);
    s1_d = PAIR_W'(r[2]) + (PAIR_W'(r[3]) << LIMB_W);
  end

  // S4: final sum; the exact product fits in C_LEN so the truncation drops only zeros
  always_comb begin
    c_d = C_LEN'(s0_q) + (C_LEN'(s1_q) << (2 * LIMB_W));
  end

  // S3/S4 data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= '0;
      s1_q <= '0;
      c_q  <= '0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
      c_q  <= c_d;
    end
  end

  logic [MUL_STAGES-1:0] vld_d, vld_q;
  logic [Q_LEN-1:0]      qch_d [MUL_STAGES];
  logic [Q_LEN-1:0]      qch_q [MUL_STAGES];

  // valid and modulus side channels shift in lockstep with S1..S4
  always_comb begin
    vld_d    = {vld_q[MUL_STAGES-2:0], mul_valid};
    qch_d[0] = mul_q;
    for (int k = 1; k < MUL_STAGES; k++) begin
      qch_d[k] = qch_q[k-1];
    end
  end

  // side channel registers; reset drops every in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < MUL_STAGES; k++) begin
        qch_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < MUL_STAGES; k++) begin
        qch_q[k] <= qch_d[k];
      end
    end
  end

  assign bus.out_valid = vld_q[MUL_STAGES-1];
  assign bus.C         = c_q;
  assign bus.q_out     = qch_q[MUL_STAGES-1];

endmodule

// File: tb/tb_int_mul_pipe.sv
// tb/tb_int_mul_pipe.sv - scoreboard bench for int_mul_pipe with directed vectors
module tb_int_mul_pipe;
  import mod_mul_pkg::*;

  localparam int LAT = INT_MUL_LAT;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;

  int_mul_pipe_if bus ();

  int_mul_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [C_LEN-1:0] exp_c   [$];
  logic [Q_LEN-1:0] exp_q   [$];
  int               exp_cyc [$];

  task automatic check(input string name, input logic [C_LEN-1:0] act, input logic [C_LEN-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: every valid output must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_c.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got C=%h q_out=%h want no output (cycle %0d)", bus.C, bus.q_out, cyc);
      end else begin
        check("product", bus.C, exp_c.pop_front());
        check("q_out", C_LEN'(bus.q_out), C_LEN'(exp_q.pop_front()));
        check("latency", C_LEN'(cyc), C_LEN'(exp_cyc.pop_front()));
      end
    end
  end

  // drive one operation for one cycle and record what must come out
  task automatic issue(input logic [Q_LEN-1:0] a, input logic [Q_LEN-1:0] b,
                       input logic [Q_LEN-1:0] q, input logic [C_LEN-1:0] c);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.q_in     = q;
    exp_c.push_back(c);
    exp_q.push_back(q);
    exp_cyc.push_back(cyc + LAT);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.q_in     = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    idle(1);
    while (exp_c.size() != 0 && budget < 4 * LAT) begin
      @(negedge clk);
      budget++;
    end
    check("drain", C_LEN'(exp_c.size()), '0);
    exp_c.delete();
    exp_q.delete();
    exp_cyc.delete();
  endtask

  task automatic check_zero_out(input string tag);
    check({tag, "_out_valid"}, C_LEN'(bus.out_valid), '0);
    check({tag, "_C"}, bus.C, '0);
    check({tag, "_q_out"}, C_LEN'(bus.q_out), '0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus.in_valid = 1'b0;
    bus.a    = '0;
    bus.b    = '0;
    bus.q_in = '0;
    repeat (2) @(negedge clk);
    check_zero_out("reset");
    rst = 1'b0;
    idle(1);

    // single op, then the following cycle must be empty
    issue(64'h8000118000000001, 64'h1, 64'h8000118000000001,
          128'h00000000000000008000118000000001);
    idle(LAT);
    check("single_next_valid", C_LEN'(bus.out_valid), '0);
    drain();

    // boundary operands
    issue(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h5,
          128'hFFFFFFFFFFFFFFFE0000000000000001);
    issue(64'h0000000100000000, 64'h0000000100000000, 64'h6,
          128'h00000000000000010000000000000000);
    issue(64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h7, 128'h0);
    issue(64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h8, 128'h0);
    issue(64'h8000000000000000, 64'h8000000000000000, 64'h9,
          128'h40000000000000000000000000000000);
    issue(64'h0001000100010001, 64'h0001000100010001, 64'hA,
          128'h00000001000200030004000300020001);
    drain();

    // streaming: eight back-to-back, one-cycle gap, one more
    issue(64'd1, 64'h10000, 64'd0, 128'h10000);
    issue(64'd2, 64'h10001, 64'd1, 128'h20002);
    issue(64'd3, 64'h10002, 64'd2, 128'h30006);
    issue(64'd4, 64'h10003, 64'd3, 128'h4000C);
    issue(64'd5, 64'h10004, 64'd4, 128'h50014);
    issue(64'd6, 64'h10005, 64'd5, 128'h6001E);
    issue(64'd7, 64'h10006, 64'd6, 128'h7002A);
    issue(64'd8, 64'h10007, 64'd7, 128'h80038);
    idle(1);
    issue(64'hFFFFFFFFFFFFFFFF, 64'h2, 64'h77, 128'h1FFFFFFFFFFFFFFFE);
    drain();

    // reset mid-flight: three ops dropped, input during reset ignored
    bus.in_valid = 1'b1;
    bus.a = 64'h11; bus.b = 64'h22; bus.q_in = 64'h33;
    @(negedge clk);
    bus.a = 64'h44; bus.b = 64'h55; bus.q_in = 64'h66;
    @(negedge clk);
    bus.a = 64'h77; bus.b = 64'h88; bus.q_in = 64'h99;
    @(negedge clk);
    rst = 1'b1;
    bus.a = 64'hFFFF; bus.b = 64'hFFFF; bus.q_in = 64'hAA;
    @(negedge clk);
    check_zero_out("midreset");
    rst = 1'b0;
    idle(2 * LAT);
    check_zero_out("post_reset");

    // pipeline still works after reset
    issue(64'h123, 64'h10, 64'h1, 128'h1230);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/int_mul_pipe.md
# int_mul_pipe

Fully pipelined 64x64 -> 128-bit unsigned integer multiplier that sits directly upstream of the Montgomery reduction stage (`mod_red_mixed`). It produces the 128-bit product `C = a*b` that the reduction stage consumes, and carries the modulus `q` alongside each product so both arrive at the reduction input in the same cycle. It accepts one operation per cycle, and a valid bit travels with every operation.

## Interface
- `Q_LEN`, 64, operand width. Fixed at 64 to match the reduction stage; other values are unsupported.
- `LIMB_W`, 16, limb width used for partial products; must divide `Q_LEN`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  `a`/`b`/`q_in` are valid this cycle.
- `a`  in  64  multiplicand.
- `b`  in  64  multiplier.
- `q_in`  in  64  modulus; passed through unmodified.
- `out_valid`  out  1  `C`/`q_out` hold a valid result.
- `C`  out  128  product `a*b`.
- `q_out`  out  64  `q_in` delayed so it aligns with `C`.

## Operation
- Operands are split into `NL = Q_LEN/LIMB_W` = 4 limbs: `a[i]`, `b[j]`.
- Stage S1: register all 16 partial products `p[i][j] = a[i]*b[j]`, each 32 bits.
- Stage S2: register 4 row sums `r[j] = sum_i p[i][j] << (i*LIMB_W)`, each 80 bits.
- Stage S3: register 2 pair sums, `s0 = r0 + (r1<<16)` and `s1 = r2 + (r3<<16)`, each 97 bits.
- Stage S4: register `C = s0 + (s1<<32)`, truncated to 128 bits. The exact product always fits in 128 bits, so no carry is lost.
- All arithmetic is unsigned.
- `valid` and `q` shift-register side channels run in lockstep with the data stages.
- The block has no backpressure. The downstream stage accepts one operation per cycle unconditionally.
- Data registers load every cycle regardless of `in_valid`. When `out_valid` = 0, `C`/`q_out` values are don't-care, except after reset (see Timing).

## Timing
- Latency is L = 4 cycles. An operation presented with `in_valid` = 1 at rising edge n appears with `out_valid` = 1 after edge n+4.
- Throughput is 1 operation per cycle. Back-to-back operations come out back-to-back in order, and gaps in the input are preserved.
- Reset values: `out_valid` = 0, `C` = 0, `q_out` = 0. Every pipeline register, including the valid chain, clears to 0.
- Reset mid-operation: all in-flight operations are dropped. `out_valid` = 0 from the first edge with `rst` = 1 and stays 0 until L edges after the first accepted input following reset release.
- `in_valid` asserted in the same cycle as `rst`: the input is ignored.
- Boundary values:
  - `a = b = 2^64-1` produces `C = 2^128 - 2^65 + 1` with no overflow.
  - A zero on either operand produces `C = 0`.

## Configuration
- `INT_MUL_IN_REG_EN`:
  - Defined: an input register stage S0 captures `a`, `b`, `q_in` and `in_valid` (valid reset to 0). Latency becomes 5, used for timing closure when operands arrive from routed logic.
  - Undefined: S1 multiplies the raw ports directly and latency is 4.
- The package constant `INT_MUL_LAT` must reflect the macro, so downstream alignment logic and benches read the latency from the package.

## Structure
- Shared package `mod_mul_pkg` holds:
  - `Q_LEN`, `LIMB_W`, `NUM_LIMBS`, `INT_MUL_LAT`;
  - the product width constant `C_LEN = 2*Q_LEN`.
- One natural sub-module, `mul_limb_row`, computes `r[j]`: it takes the 64-bit `a` and one `LIMB_W`-bit limb of `b`, registers its 4 partial products internally, then registers their 80-bit aligned sum (S1+S2 for one row).
- The top instantiates four `mul_limb_row` instances, then the S3/S4 adders and the side channels.

## Test plan
- Single op:
  - stimulus: `a=0x8000118000000001`, `b=1`, `q_in=0x8000118000000001`;
  - required: exactly L cycles later, `out_valid=1`, `C=0x00000000000000008000118000000001`, `q_out=0x8000118000000001`;
  - required next cycle: `out_valid=0`.
- Max operands:
  - stimulus: `a=b=0xFFFFFFFFFFFFFFFF`;
  - required: `C=0xFFFFFFFFFFFFFFFE0000000000000001`.
- Limb carry across the 64-bit boundary:
  - stimulus: `a=b=0x0000000100000000`;
  - required: `C=0x00000000000000010000000000000000`.
  - stimulus: `a=0`, `b=0xFFFFFFFFFFFFFFFF`;
  - required: `C=0`.
- Streaming:
  - stimulus: 8 consecutive ops with `a=k+1`, `b=0x10000+k`, `q_in=k` for k=0..7, then a one-cycle gap, then 1 more op;
  - required: 8 consecutive `out_valid` pulses with matching `C`/`q_out` in order, then one low cycle, then one pulse.
- Reset mid-flight:
  - stimulus: issue 3 ops, then assert `rst` for one cycle two cycles later;
  - required: `out_valid`, `C` and `q_out` are 0 on the edge after `rst`, and no result from the 3 ops ever appears.
- Chained with `mod_red_mixed`:
  - stimulus: pick `a`, `b` whose product is `0x82e2e662f728b4fa42485e3a0a5d2f34` (check against a software model), with `q=0x8000118000000001`;
  - required: the reduction output is `T=0x911bc037b77e25ab`.
